byte_add_chain: RTL
===================

// Module: byte_add_chain
// PURPOSE
//  Sequential multi-byte adder: streams two NBYTES-wide operands one byte per handshake, LSB first.
//  Carry ripples across cycles; each input pair yields one sum byte; the final carry-out comes with the last byte.
//  Inverse datapath of the byte subtractor; feeds the multi-byte arithmetic pipeline beside the subtract chain.
// PARAMETERS
//  NBYTES  4  operand length in bytes (>=1); one transaction = NBYTES input/output handshakes
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  begin transaction; sampled only in IDLE
//  cin        in   1  carry-in for byte 0, sampled with start
//  in_valid   in   1  a/b byte valid
//  in_ready   out  1  block accepts a/b this cycle
//  a          in   8  operand A byte
//  b          in   8  operand B byte
//  out_valid  out  1  sum byte valid
//  out_ready  in   1  consumer accepts sum
//  sum        out  8  sum byte, registered
//  out_last   out  1  sum is byte NBYTES-1
//  cout       out  1  final carry-out, valid when out_valid&&out_last
//  busy       out  1  transaction in progress (state != IDLE)
//  ovf        out  1  signed overflow of full word; exists only with BYTE_ADD_OVF_EN
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, carry=0; in_ready=0, out_valid=0, sum=0, out_last=0, cout=0, busy=0, ovf=0.
//  FSM IDLE -> RUN on start (carry<=cin, cnt<=0); start outside IDLE is ignored.
//  RUN: in_ready = !out_valid || out_ready (one-entry output reg, full throughput).
//   Accept (in_valid&&in_ready): {c,s}=a+b+carry (9-bit); sum<=s, carry<=c, out_valid<=1,
//   out_last<=(cnt==NBYTES-1), cnt<=cnt+1; last byte also drives cout<=c, then RUN -> DRAIN.
//  DRAIN: in_ready=0; on out_valid&&out_ready with out_last -> IDLE; cnt wraps to 0.
//  Output: out_valid clears on out_ready unless a new byte is accepted that same cycle (simultaneous
//   pop+push replaces the register). While out_valid&&!out_ready, sum/out_last/cout/ovf hold stable.
//  Latency: 1 cycle input handshake -> out_valid. Throughput 1 byte/cycle without backpressure.
//  in_ready=0 in IDLE and DRAIN; a/b offered there are not consumed.
//  cout and ovf low except on the out_last beat; out_last low on all other beats.
//  Reset mid-transaction: immediate abort to reset values; partial result discarded.
//  NBYTES=1: start -> one accept -> DRAIN; cnt width = max(1,$clog2(NBYTES)).
// CONFIGURATION
//  BYTE_ADD_OVF_EN defined: ovf port present; on last byte ovf<=(a[7]==b[7])&&(s[7]!=a[7]),
//   registered with sum, held under backpressure, 0 on other beats.
//  Not defined: no ovf port, no overflow logic; all other behaviour identical.
// STRUCTURE
//  Shared include byte_arith_defs.vh: BYTE_W=8, FSM encodings ST_IDLE/ST_RUN/ST_DRAIN (2-bit),
//   shared with the subtract chain.
//  Sub-module byte_adder (combinational): ports A,B,c -> O (8b sum), o (carry), mirroring the
//   subtractor's port order; top holds FSM, counter, carry reg and output register.
// TESTING
//  1 Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately, busy=0, in_ready=0.
//  2 NBYTES=4, cin=0, A=0x000000FF, B=0x00000001 -> sums 00,01,00,00; out_last on 4th; cout=0.
//  3 cin=0, A=0xFFFFFFFF, B=0x00000001 -> sums 00,00,00,00, cout=1; cin=1, A=B=0 -> 01,00,00,00.
//  4 Backpressure: out_ready=0 for 3 cycles after byte 0 -> in_ready=0, sum=byte0 stable;
//    release -> remaining bytes in order, none lost/duplicated; start pulsed in RUN ignored.
//  5 Reset after 2 bytes accepted -> all cleared; new start cin=1, A=B=0x00000000 -> 01,00,00,00.
//  6 BYTE_ADD_OVF_EN: A=0x7F000000, B=0x01000000 -> last sum 0x80, ovf=1, cout=0;
//    A=B=0x80000000 -> ovf=1, cout=1; macro off -> build has no ovf port, sums unchanged.

Source files
------------

// File: rtl/byte_add_chain_pkg.sv
// Shared byte-arithmetic definitions: byte width, chain FSM encoding, counter sizing.
// Used by both the add chain and its byte_adder datapath.
package byte_add_chain_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A one-byte chain still needs a 1-bit counter to keep the ports well-formed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_adder.sv
// Combinational 8-bit full adder slice: O = A + B + c, o = carry-out.
// Port order matches the byte subtractor slice.
module byte_adder
  import byte_add_chain_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              c,
  output logic [BYTE_W-1:0] O,
  output logic              o
);

  logic [BYTE_W:0] full;

  always_comb begin
    full = {1'b0, A} + {1'b0, B} + {{BYTE_W{1'b0}}, c};
    O    = full[BYTE_W-1:0];
    o    = full[BYTE_W];
  end

endmodule

// File: rtl/byte_add_chain.sv
// Sequential NBYTES-wide adder, one byte per handshake LSB first; 1-cycle accept->out_valid.
// Optional BYTE_ADD_OVF_EN adds the signed-overflow output on the last beat.
module byte_add_chain
  import byte_add_chain_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] sum,
  output logic              out_last,
  output logic              cout,
  output logic              busy
`ifdef BYTE_ADD_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int CNT_W = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              cout_q, cout_d;
  logic [BYTE_W-1:0] add_s;
  logic              add_c;
  logic              accept;
  logic              pop;
  logic              is_last;
`ifdef BYTE_ADD_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  byte_adder u_add (
    .A (a),
    .B (b),
    .c (carry_q),
    .O (add_s),
    .o (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cout_q      <= 1'b0;
`ifdef BYTE_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cout_q      <= cout_d;
`ifdef BYTE_ADD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cout_d      = cout_q;
`ifdef BYTE_ADD_OVF_EN
    ovf_d       = ovf_q;
`endif
    is_last     = (cnt_q == CNT_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // A same-cycle pop and push simply overwrites the output register.
        if (accept) begin
          sum_d       = add_s;
          carry_d     = add_c;
          out_valid_d = 1'b1;
          out_last_d  = is_last;
          cout_d      = is_last & add_c;
`ifdef BYTE_ADD_OVF_EN
          ovf_d       = is_last & (a[7] == b[7]) & (add_s[7] != a[7]);
`endif
          cnt_d       = is_last ? '0 : cnt_q + CNT_W'(1);
          if (is_last) state_d = ST_DRAIN;
        end else if (pop) begin
          out_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (pop) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d    = ST_IDLE;
            out_last_d = 1'b0;
            cout_d     = 1'b0;
`ifdef BYTE_ADD_OVF_EN
            ovf_d      = 1'b0;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    pop       = out_valid_q && out_ready;
    busy      = (state_q != ST_IDLE);
    out_valid = out_valid_q;
    sum       = sum_q;
    out_last  = out_last_q;
    cout      = cout_q;
`ifdef BYTE_ADD_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule
